// File: rtl/pep_ldb_blram_writer.sv
// rtl/pep_ldb_blram_writer.sv - packs BLWE coefficient beats into subword writes for the key-switch BLWE RAM
module pep_ldb_blram_writer #(
    parameter int OP_W          = 32,
    parameter int PID_W         = 6,
    parameter int KS_IF_COEF_NB = 4,
    parameter int KS_IF_SUBW_NB = 1,
    parameter int BLWE_COEF_NB  = 631
) (
    input  logic                                      clk,
    input  logic                                      s_rst_n,
    input  logic [PID_W-1:0]                          cmd_pid,
    input  logic                                      cmd_pbs_last,
    input  logic                                      cmd_vld,
    output logic                                      cmd_rdy,
    input  logic [KS_IF_COEF_NB*OP_W-1:0]             in_data,
    input  logic                                      in_vld,
    output logic                                      in_rdy,
    output logic [KS_IF_SUBW_NB-1:0]                  ldb_blram_wr_en,
    output logic [KS_IF_SUBW_NB*PID_W-1:0]            ldb_blram_wr_pid,
    output logic [KS_IF_SUBW_NB*KS_IF_COEF_NB*OP_W-1:0] ldb_blram_wr_data,
    output logic                                      ldb_blram_wr_pbs_last,
    output logic                                      ldb_seq_done,
    output logic [PID_W-1:0]                          ldb_seq_done_pid
);
    localparam int BEAT_NB      = (BLWE_COEF_NB + KS_IF_COEF_NB - 1) / KS_IF_COEF_NB;
    localparam int LAST_COEF_NB = BLWE_COEF_NB - (BEAT_NB - 1) * KS_IF_COEF_NB;
    localparam int BEAT_W       = (BEAT_NB > 1) ? $clog2(BEAT_NB) : 1;
    localparam int SUBW_W       = (KS_IF_SUBW_NB > 1) ? $clog2(KS_IF_SUBW_NB) : 1;
    localparam int BEAT_DW      = KS_IF_COEF_NB * OP_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEAT_NB - 1);
    localparam logic [SUBW_W-1:0] LAST_SUBW = SUBW_W'(KS_IF_SUBW_NB - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                                 state;
    state_t                                 state_nxt;
    logic [PID_W-1:0]                       pid;
    logic                                   pbs_last;
    logic [BEAT_W-1:0]                      beat_cnt;
    logic [SUBW_W-1:0]                      subw_idx;
    logic [KS_IF_SUBW_NB-1:0][BEAT_DW-1:0]  buffer;
    logic [KS_IF_SUBW_NB-1:0][BEAT_DW-1:0]  buffer_nxt;
    logic [KS_IF_SUBW_NB-1:0][BEAT_DW-1:0]  wr_data_nxt;
    logic [KS_IF_SUBW_NB-1:0][BEAT_DW-1:0]  wr_data_q;
    logic [KS_IF_SUBW_NB-1:0]               wr_en_nxt;
    logic [BEAT_DW-1:0]                     beat_masked;
    logic                                   cmd_acc;
    logic                                   beat_acc;
    logic                                   last_beat;
    logic                                   final_beat;
    logic                                   flush;

    assign cmd_acc    = cmd_vld & cmd_rdy;
    assign beat_acc   = in_vld & in_rdy;
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign final_beat = beat_acc & last_beat;
    // A write goes out when the group of subwords is full or the BLWE ends.
    assign flush      = beat_acc & ((subw_idx == LAST_SUBW) | last_beat);

    assign ldb_blram_wr_data = wr_data_q;

    // State register.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and handshake outputs; cmd_rdy stays low while reset is held.
    always_comb begin
        state_nxt = state;
        cmd_rdy   = 1'b0;
        in_rdy    = 1'b0;
        case (state)
            IDLE: begin
                cmd_rdy = s_rst_n;
                if (cmd_vld && s_rst_n) state_nxt = LOAD;
            end
            LOAD: begin
                in_rdy = 1'b1;
                if (in_vld && last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Zero the padding lanes of the final beat, slot it into the group and build the write word.
    always_comb begin
        beat_masked = in_data;
        if (last_beat) begin
            for (int l = LAST_COEF_NB; l < KS_IF_COEF_NB; l++)
                beat_masked[l*OP_W +: OP_W] = '0;
        end
        buffer_nxt  = buffer;
        wr_en_nxt   = '0;
        wr_data_nxt = '0;
        for (int s = 0; s < KS_IF_SUBW_NB; s++) begin
            if (SUBW_W'(s) == subw_idx) buffer_nxt[s] = beat_masked;
            wr_en_nxt[s] = (SUBW_W'(s) <= subw_idx);
            if (wr_en_nxt[s]) wr_data_nxt[s] = buffer_nxt[s];
        end
    end

    // Command latch, beat/subword counters and partial-group buffer.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            pid      <= '0;
            pbs_last <= 1'b0;
            beat_cnt <= '0;
            subw_idx <= '0;
            buffer   <= '0;
        end else begin
            if (cmd_acc) begin
                pid      <= cmd_pid;
                pbs_last <= cmd_pbs_last;
            end
            if (beat_acc) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
                if (flush) begin
                    subw_idx <= '0;
                    buffer   <= '0;
                end else begin
                    subw_idx <= subw_idx + SUBW_W'(1);
                    buffer   <= buffer_nxt;
                end
            end
        end
    end

    // Registered write pulse and completion report.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ldb_blram_wr_en       <= '0;
            ldb_blram_wr_pid      <= '0;
            wr_data_q             <= '0;
            ldb_blram_wr_pbs_last <= 1'b0;
            ldb_seq_done          <= 1'b0;
            ldb_seq_done_pid      <= '0;
        end else begin
            ldb_blram_wr_en       <= flush ? wr_en_nxt : '0;
            ldb_blram_wr_pid      <= flush ? {KS_IF_SUBW_NB{pid}} : '0;
            wr_data_q             <= flush ? wr_data_nxt : '0;
            ldb_blram_wr_pbs_last <= final_beat & pbs_last;
            ldb_seq_done          <= final_beat;
            if (final_beat) ldb_seq_done_pid <= pid;
        end
    end
endmodule

// File: tb/tb_pep_ldb_blram_writer.sv
// tb/tb_pep_ldb_blram_writer.sv - scoreboard bench for pep_ldb_blram_writer
module tb_pep_ldb_blram_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [5:0]   a_cmd_pid = '0, b_cmd_pid = '0;
    logic         a_cmd_pbs = 1'b0, b_cmd_pbs = 1'b0;
    logic         a_cmd_vld = 1'b0, b_cmd_vld = 1'b0;
    logic         a_cmd_rdy, b_cmd_rdy;
    logic [127:0] a_in_data = '0, b_in_data = '0;
    logic         a_in_vld = 1'b0, b_in_vld = 1'b0;
    logic         a_in_rdy, b_in_rdy;
    logic [1:0]   a_wr_en;
    logic [0:0]   b_wr_en;
    logic [11:0]  a_wr_pid;
    logic [5:0]   b_wr_pid;
    logic [255:0] a_wr_data;
    logic [127:0] b_wr_data;
    logic         a_wr_pbs, b_wr_pbs;
    logic         a_done, b_done;
    logic [5:0]   a_done_pid, b_done_pid;

    pep_ldb_blram_writer #(.OP_W(32), .PID_W(6), .KS_IF_COEF_NB(4), .KS_IF_SUBW_NB(2), .BLWE_COEF_NB(10)) dut_a (
        .clk(clk), .s_rst_n(rst_n),
        .cmd_pid(a_cmd_pid), .cmd_pbs_last(a_cmd_pbs), .cmd_vld(a_cmd_vld), .cmd_rdy(a_cmd_rdy),
        .in_data(a_in_data), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
        .ldb_blram_wr_en(a_wr_en), .ldb_blram_wr_pid(a_wr_pid), .ldb_blram_wr_data(a_wr_data),
        .ldb_blram_wr_pbs_last(a_wr_pbs), .ldb_seq_done(a_done), .ldb_seq_done_pid(a_done_pid)
    );

    pep_ldb_blram_writer #(.OP_W(32), .PID_W(6), .KS_IF_COEF_NB(4), .KS_IF_SUBW_NB(1), .BLWE_COEF_NB(8)) dut_b (
        .clk(clk), .s_rst_n(rst_n),
        .cmd_pid(b_cmd_pid), .cmd_pbs_last(b_cmd_pbs), .cmd_vld(b_cmd_vld), .cmd_rdy(b_cmd_rdy),
        .in_data(b_in_data), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
        .ldb_blram_wr_en(b_wr_en), .ldb_blram_wr_pid(b_wr_pid), .ldb_blram_wr_data(b_wr_data),
        .ldb_blram_wr_pbs_last(b_wr_pbs), .ldb_seq_done(b_done), .ldb_seq_done_pid(b_done_pid)
    );

    typedef struct {
        int           cyc;
        logic [1:0]   en;
        logic [255:0] data;
        logic [11:0]  pid;
        logic         pbs;
        logic         done;
        logic [5:0]   done_pid;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_cmd_rdy(input int inst);
        return (inst != 0) ? b_cmd_rdy : a_cmd_rdy;
    endfunction

    function automatic logic get_in_rdy(input int inst);
        return (inst != 0) ? b_in_rdy : a_in_rdy;
    endfunction

    task automatic set_cmd(input int inst, input logic vld, input logic [5:0] pid, input logic pbs);
        if (inst != 0) begin b_cmd_vld = vld; b_cmd_pid = pid; b_cmd_pbs = pbs; end
        else           begin a_cmd_vld = vld; a_cmd_pid = pid; a_cmd_pbs = pbs; end
    endtask

    task automatic set_in(input int inst, input logic vld, input logic [127:0] data);
        if (inst != 0) begin b_in_vld = vld; b_in_data = data; end
        else           begin a_in_vld = vld; a_in_data = data; end
    endtask

    task automatic send_cmd(input int inst, input logic [5:0] pid, input logic pbs);
        int n = 0;
        set_cmd(inst, 1'b1, pid, pbs);
        while (!get_cmd_rdy(inst) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_rdy_wait", get_cmd_rdy(inst), 1'b1);
        @(posedge clk); #1;
        set_cmd(inst, 1'b0, '0, 1'b0);
    endtask

    // One full BLWE: command, then beats with an optional gap after beat gap_beat.
    task automatic run_blwe(input int inst, input logic [5:0] pid, input logic pbs,
                            input int gap_beat, input int gap_len, input logic [31:0] base);
        int subw, ncoef, nbeat, g, bs, idx, n;
        logic [127:0] d;
        exp_t e;
        subw  = (inst != 0) ? 1 : 2;
        ncoef = (inst != 0) ? 8 : 10;
        nbeat = (ncoef + 3) / 4;
        send_cmd(inst, pid, pbs);
        for (int b = 0; b < nbeat; b++) begin
            for (int l = 0; l < 4; l++) begin
                idx = b * 4 + l;
                d[l*32 +: 32] = (idx < ncoef) ? base + 32'(idx) + 32'd1 : 32'hDEAD_0000 | 32'(idx);
            end
            set_in(inst, 1'b1, d);
            n = 0;
            while (!get_in_rdy(inst) && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("in_rdy_wait", get_in_rdy(inst), 1'b1);
            @(posedge clk); #1;
            if ((b % subw == subw - 1) || (b == nbeat - 1)) begin
                e.cyc = cyc;
                e.en = '0;
                e.data = '0;
                e.pid = (subw == 2) ? {pid, pid} : {6'd0, pid};
                g = b / subw;
                for (int s = 0; s < subw; s++) begin
                    bs = g * subw + s;
                    if (bs <= b) begin
                        e.en[s] = 1'b1;
                        for (int l = 0; l < 4; l++) begin
                            idx = bs * 4 + l;
                            if (idx < ncoef) e.data[(s*4+l)*32 +: 32] = base + 32'(idx) + 32'd1;
                        end
                    end
                end
                e.pbs = (b == nbeat - 1) && pbs;
                e.done = (b == nbeat - 1);
                e.done_pid = pid;
                if (inst != 0) qb.push_back(e);
                else           qa.push_back(e);
            end
            if (b == gap_beat) begin
                set_in(inst, 1'b0, '0);
                repeat (gap_len) begin @(posedge clk); #1; end
            end
        end
        set_in(inst, 1'b0, '0);
    endtask

    // Scoreboard for instance A.
    always @(negedge clk) begin
        exp_t e;
        if (a_wr_en != '0 || a_done || a_wr_pbs) begin
            if (qa.size() == 0) begin
                check("a_unexpected_wr", {a_wr_en, a_done, a_wr_pbs}, '0);
            end else begin
                e = qa.pop_front();
                check("a_wr_cyc", cyc, e.cyc);
                check("a_wr_en", a_wr_en, e.en);
                check("a_wr_data", a_wr_data, e.data);
                check("a_wr_pid", a_wr_pid, e.pid);
                check("a_wr_pbs_last", a_wr_pbs, e.pbs);
                check("a_done", a_done, e.done);
                if (e.done) check("a_done_pid", a_done_pid, e.done_pid);
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        exp_t e;
        if (b_wr_en != '0 || b_done || b_wr_pbs) begin
            if (qb.size() == 0) begin
                check("b_unexpected_wr", {b_wr_en, b_done, b_wr_pbs}, '0);
            end else begin
                e = qb.pop_front();
                check("b_wr_cyc", cyc, e.cyc);
                check("b_wr_en", b_wr_en, e.en);
                check("b_wr_data", b_wr_data, e.data);
                check("b_wr_pid", b_wr_pid, e.pid);
                check("b_wr_pbs_last", b_wr_pbs, e.pbs);
                check("b_done", b_done, e.done);
                if (e.done) check("b_done_pid", b_done_pid, e.done_pid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_cmd_rdy", a_cmd_rdy, 1'b0);
        check("rst_a_in_rdy", a_in_rdy, 1'b0);
        check("rst_a_wr_en", a_wr_en, '0);
        check("rst_a_done", a_done, 1'b0);
        check("rst_b_wr_data", b_wr_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_a_cmd_rdy", a_cmd_rdy, 1'b1);
        check("post_rst_b_cmd_rdy", b_cmd_rdy, 1'b1);
        check("post_rst_a_in_rdy", a_in_rdy, 1'b0);

        run_blwe(0, 6'd5, 1'b1, -1, 0, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        run_blwe(0, 6'd9, 1'b0, -1, 0, 32'd100);
        repeat (3) begin @(posedge clk); #1; end
        run_blwe(0, 6'd12, 1'b1, 0, 3, 32'd200);
        repeat (3) begin @(posedge clk); #1; end

        send_cmd(0, 6'd3, 1'b1);
        set_in(0, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1});
        @(posedge clk); #1;
        set_in(0, 1'b0, '0);
        check("mid_load_in_rdy", a_in_rdy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_rdy", a_in_rdy, 1'b0);
        check("mid_rst_cmd_rdy", a_cmd_rdy, 1'b0);
        check("mid_rst_wr_en", a_wr_en, '0);
        check("mid_rst_done", a_done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rel_rst_cmd_rdy", a_cmd_rdy, 1'b1);
        check("rel_rst_in_rdy", a_in_rdy, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        run_blwe(0, 6'd7, 1'b1, -1, 0, 32'd300);
        repeat (3) begin @(posedge clk); #1; end

        run_blwe(1, 6'd1, 1'b1, -1, 0, 32'd0);
        check("b2b_done", b_done, 1'b1);
        check("b2b_cmd_rdy", b_cmd_rdy, 1'b1);
        run_blwe(1, 6'd2, 1'b0, -1, 0, 32'd50);
        repeat (3) begin @(posedge clk); #1; end

        set_in(1, 1'b1, {4{32'hBAD0_BAD0}});
        repeat (5) begin
            @(posedge clk); #1;
            check("idle_in_rdy", b_in_rdy, 1'b0);
        end
        set_in(1, 1'b0, '0);
        run_blwe(1, 6'd3, 1'b1, -1, 0, 32'd70);

        repeat (6) begin @(posedge clk); #1; end
        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
